// File: rtl/ms_ctrl.sv
// Minesweeper sequencing controller: handshake intake, ordered datapath strobes, move count, watchdog.
// Optional selection screening is enabled by defining MS_SEL_CHECK_EN.
module ms_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        new_game,
  input  logic        in_valid,
  input  logic [4:0]  in_data,
  output logic        in_ready,
  input  logic        alu_done,
  input  logic        display_done,
  input  logic        gameover,
  input  logic        win,
  input  logic [24:0] cleared,
  output logic        start,
  output logic        load,
  output logic        decode,
  output logic        alu,
  output logic        display,
  output logic [4:0]  data,
  output logic [4:0]  moves,
  output logic        reject,
  output logic        game_won,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, START, WAIT_IN, LOAD, DECODE, ALU, DISP, OVER
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
  localparam logic [4:0] MAX_MOVES = 5'd25;

  state_t      state_q, state_d;
  logic [4:0]  data_q, data_d;
  logic [4:0]  moves_q, moves_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        game_won_q, game_won_d;
  logic        err_q, err_d;
  logic        reject_q, reject_d;
  logic [4:0]  strobe_q, strobe_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        sel_bad;

`ifdef MS_SEL_CHECK_EN
  logic [31:0] cleared_ext;
  assign cleared_ext = {7'd0, cleared};
  assign sel_bad     = (in_data >= MAX_MOVES) || cleared_ext[in_data];
`else
  logic unused_cleared;
  assign unused_cleared = ^cleared;
  assign sel_bad        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    moves_d    = moves_q;
    wdog_d     = wdog_q;
    game_won_d = game_won_q;
    err_d      = err_q;
    reject_d   = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (new_game) begin
          state_d    = START;
          moves_d    = '0;
          game_won_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      START: state_d = WAIT_IN;
      WAIT_IN: begin
        if (new_game) begin
          state_d = START;
        end else if (in_valid) begin
          if (sel_bad) begin
            reject_d = 1'b1;
          end else begin
            data_d  = in_data;
            state_d = LOAD;
          end
        end
      end
      LOAD: state_d = DECODE;
      DECODE: begin
        state_d = ALU;
        wdog_d  = '0;
      end
      ALU: begin
        if (alu_done) begin
          moves_d = (moves_q == MAX_MOVES) ? moves_q : moves_q + 5'd1;
          wdog_d  = '0;
          state_d = DISP;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      DISP: begin
        if (display_done) begin
          if (gameover) begin
            state_d    = OVER;
            game_won_d = win;
          end else begin
            state_d = WAIT_IN;
          end
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    strobe_d   = {state_d == START, state_d == LOAD, state_d == DECODE,
                  state_d == ALU, state_d == DISP};
    in_ready_d = (state_d == WAIT_IN);
    busy_d     = !(state_d inside {IDLE, WAIT_IN, OVER});
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q    <= IDLE;
      data_q     <= '0;
      moves_q    <= '0;
      wdog_q     <= '0;
      game_won_q <= 1'b0;
      err_q      <= 1'b0;
      reject_q   <= 1'b0;
      strobe_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      moves_q    <= moves_d;
      wdog_q     <= wdog_d;
      game_won_q <= game_won_d;
      err_q      <= err_d;
      reject_q   <= reject_d;
      strobe_q   <= strobe_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign {start, load, decode, alu, display} = strobe_q;
  assign data     = data_q;
  assign moves    = moves_q;
  assign reject   = reject_q;
  assign game_won = game_won_q;
  assign err      = err_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

endmodule
